// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: captures a word, drives it and a stepping bit index
// to a downstream combinational mux, and rebuilds the word from the mux
// result. Mismatches between the returned bits and the captured word are
// counted, and the index of the first one is recorded.
module mux_scan_sequencer #(
  parameter int width    = 16,
  parameter int channels = 4,
  parameter int settle   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [width-1:0]    data_in,
  output logic [width-1:0]    data_out,
  output logic [channels-1:0] sel_out,
  input  logic                mux_in,
  output logic                busy,
  output logic                done,
  output logic [width-1:0]    word_out,
  output logic                error,
  output logic [channels-1:0] err_index,
  output logic [channels:0]   err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0]          SETTLE_CNT = 4'(settle);
  localparam logic [channels-1:0] LAST_IDX   = channels'(width - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       bit_err;

  // The mux answers combinationally from the registered data/select, so
  // the result for the current index is valid by the next edge.
  assign bit_err = (mux_in != data_out[sel_out]);

  // Status flags decode straight from the state register.
  assign busy = (state == SCAN);
  assign done = (state == DONE);

  // Scan sequencing: capture, step through each index, then one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= '0;
      sel_out   <= '0;
      wait_cnt  <= '0;
      word_out  <= '0;
      error     <= 1'b0;
      err_index <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out  <= data_in;
            sel_out   <= '0;
            wait_cnt  <= SETTLE_CNT;
            word_out  <= '0;
            error     <= 1'b0;
            err_index <= '0;
            err_count <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            word_out[sel_out] <= mux_in;
            if (bit_err) begin
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              if (!error) begin
                error     <= 1'b1;
                err_index <= sel_out;
              end
            end
            if (sel_out == LAST_IDX) begin
              state <= DONE;
            end else begin
              sel_out  <= sel_out + 1'b1;
              wait_cnt <= SETTLE_CNT;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a looped-back behavioural mux.
// Instance u_dut0 uses settle=0, u_dut1 uses settle=2.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0;
  logic [15:0] data_in0 = '0;
  logic [15:0] data_out0;
  logic [3:0]  sel_out0;
  logic        mux_in0;
  logic        busy0, done0, error0;
  logic [15:0] word_out0;
  logic [3:0]  err_index0;
  logic [4:0]  err_count0;

  logic        start1 = 1'b0;
  logic [15:0] data_in1 = '0;
  logic [15:0] data_out1;
  logic [3:0]  sel_out1;
  logic        mux_in1;
  logic        busy1, done1, error1;
  logic [15:0] word_out1;
  logic [3:0]  err_index1;
  logic [4:0]  err_count1;

  logic        inj = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural mux loopback, with optional bit inversion at indices 5 and 9.
  assign mux_in0 = data_out0[sel_out0] ^ (inj && (sel_out0 == 4'd5 || sel_out0 == 4'd9));
  assign mux_in1 = data_out1[sel_out1];

  mux_scan_sequencer #(.width(16), .channels(4), .settle(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data_in0),
    .data_out(data_out0), .sel_out(sel_out0), .mux_in(mux_in0),
    .busy(busy0), .done(done0), .word_out(word_out0), .error(error0),
    .err_index(err_index0), .err_count(err_count0)
  );

  mux_scan_sequencer #(.width(16), .channels(4), .settle(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in1),
    .data_out(data_out1), .sel_out(sel_out1), .mux_in(mux_in1),
    .busy(busy1), .done(done1), .word_out(word_out1), .error(error1),
    .err_index(err_index1), .err_count(err_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse on dut0; returns at the negedge after the accepting edge.
  task automatic pulse_start0(input logic [15:0] d);
    data_in0 = d;
    start0   = 1'b1;
    @(negedge clk);
    start0   = 1'b0;
  endtask

  // Runs dut0 until the scan has finished, counting busy and done cycles.
  // poke=1 pulses start and drives data_in to FFFF while sel_out is 7.
  task automatic finish0(input bit poke, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 80; k++) begin
      if (busy0) busy_n++;
      if (done0) done_n++;
      if (!busy0 && !done0 && done_n > 0) break;
      if (poke && busy0 && sel_out0 == 4'd7) begin
        start0   = 1'b1;
        data_in0 = 16'hFFFF;
      end else begin
        start0   = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  initial begin
    int bn, dn;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_data_out", data_out0, 0);
    chk("rst_sel_out", sel_out0, 0);
    chk("rst_word_out", word_out0, 0);
    chk("rst_error", error0, 0);
    chk("rst_err_index", err_index0, 0);
    chk("rst_err_count", err_count0, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean scan, cycle by cycle.
    pulse_start0(16'hA5C3);
    chk("clean_data_out", data_out0, 16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("clean_busy_%0d", i), busy0, 1);
      chk($sformatf("clean_sel_%0d", i), sel_out0, i);
      chk($sformatf("clean_nodone_%0d", i), done0, 0);
      @(negedge clk);
    end
    chk("clean_done", done0, 1);
    chk("clean_busy_off", busy0, 0);
    chk("clean_word", word_out0, 16'hA5C3);
    chk("clean_error", error0, 0);
    chk("clean_err_count", err_count0, 0);
    @(negedge clk);
    chk("clean_done_off", done0, 0);
    chk("clean_hold_word", word_out0, 16'hA5C3);

    // Fault injection at indices 5 and 9.
    inj = 1'b1;
    pulse_start0(16'hA5C3);
    finish0(1'b0, bn, dn);
    inj = 1'b0;
    chk("fault_busy_cycles", bn, 16);
    chk("fault_done_pulses", dn, 1);
    chk("fault_word", word_out0, 16'hA7E3);
    chk("fault_error", error0, 1);
    chk("fault_err_index", err_index0, 5);
    chk("fault_err_count", err_count0, 2);

    // Start and data_in changes during the scan are ignored.
    pulse_start0(16'hA5C3);
    finish0(1'b1, bn, dn);
    chk("ign_busy_cycles", bn, 16);
    chk("ign_done_pulses", dn, 1);
    chk("ign_word", word_out0, 16'hA5C3);
    chk("ign_error", error0, 0);
    chk("ign_idle", busy0, 0);
    pulse_start0(data_in0);
    chk("ign_capture_ffff", data_out0, 16'hFFFF);
    finish0(1'b0, bn, dn);
    chk("ffff_word", word_out0, 16'hFFFF);
    chk("ffff_busy_cycles", bn, 16);

    // Reset in the middle of a scan.
    pulse_start0(16'hA5C3);
    for (int k = 0; k < 20 && sel_out0 != 4'd7; k++) @(negedge clk);
    chk("mid_at_sel7", sel_out0, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy0, 0);
    chk("mid_sel", sel_out0, 0);
    chk("mid_word", word_out0, 0);
    chk("mid_done", done0, 0);
    @(negedge clk);
    chk("mid_done_next", done0, 0);
    chk("mid_busy_next", busy0, 0);
    pulse_start0(16'h3C5A);
    finish0(1'b0, bn, dn);
    chk("post_busy_cycles", bn, 16);
    chk("post_done_pulses", dn, 1);
    chk("post_word", word_out0, 16'h3C5A);

    // settle=2: each index held three cycles.
    data_in1 = 16'h0001;
    start1   = 1'b1;
    @(negedge clk);
    start1   = 1'b0;
    bn = 0;
    for (int k = 0; k < 100 && busy1; k++) begin
      chk($sformatf("settle_sel_c%0d", bn), sel_out1, bn / 3);
      bn++;
      @(negedge clk);
    end
    chk("settle_busy_cycles", bn, 48);
    chk("settle_done", done1, 1);
    chk("settle_word", word_out1, 16'h0001);
    chk("settle_error", error1, 0);
    @(negedge clk);
    chk("settle_done_off", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
